// File: rtl/ni_packetizer_pkg.sv
// Shared definitions for the NI packetizer: flit_id encodings, header field
// offsets, FSM state enum and the header-word builder.
package ni_packetizer_pkg;

  localparam logic [2:0] FLIT_HEADER  = 3'b001;
  localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
  localparam logic [2:0] FLIT_TAIL    = 3'b100;

  localparam int HDR_DST_LSB = 0;
  localparam int HDR_SRC_LSB = 4;
  localparam int HDR_LEN_LSB = 8;
  localparam int HDR_ID_LSB  = 16;
  localparam int HDR_WIDTH   = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_BODY  = 2'd2,
    ST_DRAIN = 2'd3
  } ni_state_e;

  function automatic logic [HDR_WIDTH-1:0] build_header(
    input logic [3:0] dst,
    input logic [3:0] src,
    input logic [7:0] len,
    input logic [7:0] id
  );
    logic [HDR_WIDTH-1:0] h;
    h = '0;
    h[HDR_DST_LSB +: 4] = dst;
    h[HDR_SRC_LSB +: 4] = src;
    h[HDR_LEN_LSB +: 8] = len;
    h[HDR_ID_LSB  +: 8] = id;
    return h;
  endfunction

endpackage

// File: rtl/ni_flit_reg.sv
// Single-entry flit output register with valid/ready hold; free_o says it can
// take a new flit this cycle (empty or draining).
module ni_flit_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [2:0]            id_i,
  input  logic [3:0]            dst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  free_o,
  output logic                  valid_o,
  output logic [2:0]            id_o,
  output logic [3:0]            dst_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q;
  logic [2:0]            id_q;
  logic [3:0]            dst_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign free_o  = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign id_o    = id_q;
  assign dst_o   = dst_q;
  assign data_o  = data_q;

  // Holding register: a load is only honoured when the slot is free, so the
  // fields never change under a stalled flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      id_q    <= 3'b000;
      dst_q   <= 4'h0;
      data_q  <= '0;
    end else if (load_i && free_o) begin
      valid_q <= 1'b1;
      id_q    <= id_i;
      dst_q   <= dst_i;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ni_packetizer.sv
// NI transmitter: turns a packet command plus body words into a
// HEADER/PAYLOAD/TAIL flit stream for the router's Local input FIFO.
module ni_packetizer
  import ni_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            cur_addr_rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [3:0]            pkt_dst,
  input  logic [7:0]            pkt_len,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic [2:0]            flit_id,
  output logic [3:0]            dst_addr,
  output logic [DATA_WIDTH-1:0] flit_data,
  output logic                  pkt_done,
  output logic                  err_len
);

  ni_state_e state_q, state_d;
  logic [3:0] cur_addr_q;
  logic [3:0] dst_q, dst_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] pkt_id_q, pkt_id_d;
  logic       err_q, err_d;

  logic                  ld_s;
  logic [2:0]            ld_id_s;
  logic [3:0]            ld_dst_s;
  logic [DATA_WIDTH-1:0] ld_data_s;
  logic                  free_s;
  logic                  xfer_s;
  logic                  cmd_phase_s;
  logic                  len_ok_s;

  assign xfer_s   = flit_valid & flit_ready;
  assign len_ok_s = (pkt_len != 8'd0) && ({24'd0, pkt_len} <= 32'(MAX_LEN));
  assign err_len  = err_q;

  // Control registers; cur_addr is re-sampled every reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= cur_addr_rst;
      dst_q      <= 4'h0;
      rem_q      <= 8'd0;
      pkt_id_q   <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      pkt_id_q <= pkt_id_d;
      err_q    <= err_d;
    end
  end

  // Next-state, handshakes and output-register load selection.
  always_comb begin
    state_d     = state_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    pkt_id_d    = pkt_id_q;
    err_d       = 1'b0;
    ld_s        = 1'b0;
    ld_id_s     = FLIT_PAYLOAD;
    ld_dst_s    = dst_q;
    ld_data_s   = '0;
    data_ready  = 1'b0;
    pkt_done    = 1'b0;
    cmd_phase_s = 1'b0;

    case (state_q)
      ST_IDLE: cmd_phase_s = 1'b1;
      ST_HDR: begin
        if (xfer_s) state_d = ST_BODY;
        else        state_d = ST_HDR;
      end
      ST_BODY: begin
        data_ready = free_s & ~rst;
        if (data_valid && data_ready) begin
          ld_s      = 1'b1;
          ld_data_s = data_in;
          rem_d     = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            ld_id_s = FLIT_TAIL;
            state_d = ST_DRAIN;
          end else begin
            ld_id_s = FLIT_PAYLOAD;
          end
        end else begin
          ld_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        // The TAIL leaving frees the register, so a new command may start now.
        if (xfer_s) begin
          pkt_done    = ~rst;
          pkt_id_d    = pkt_id_q + 8'd1;
          state_d     = ST_IDLE;
          cmd_phase_s = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pkt_ready = cmd_phase_s & free_s & ~rst;
    if (pkt_valid && pkt_ready) begin
      if (len_ok_s) begin
        dst_d     = pkt_dst;
        rem_d     = pkt_len;
        state_d   = ST_HDR;
        ld_s      = 1'b1;
        ld_id_s   = FLIT_HEADER;
        ld_dst_s  = pkt_dst;
        ld_data_s = '0;
        ld_data_s[HDR_WIDTH-1:0] = build_header(pkt_dst, cur_addr_q, pkt_len, pkt_id_d);
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = 1'b0;
    end
  end

  ni_flit_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_flit_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld_s),
    .id_i    (ld_id_s),
    .dst_i   (ld_dst_s),
    .data_i  (ld_data_s),
    .ready_i (flit_ready),
    .free_o  (free_s),
    .valid_o (flit_valid),
    .id_o    (flit_id),
    .dst_o   (dst_addr),
    .data_o  (flit_data)
  );

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed bench for ni_packetizer: vector table for the basic packet flows
// plus hand sequences for stall, reset-abort and pkt_id wrap.
module tb_ni_packetizer;

  localparam int DW = 32;
  localparam logic [2:0] ID_H = 3'b001;
  localparam logic [2:0] ID_P = 3'b010;
  localparam logic [2:0] ID_T = 3'b100;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    cur_addr_rst;
  logic          pkt_valid, pkt_ready;
  logic [3:0]    pkt_dst;
  logic [7:0]    pkt_len;
  logic          data_valid, data_ready;
  logic [DW-1:0] data_in;
  logic          flit_valid, flit_ready;
  logic [2:0]    flit_id;
  logic [3:0]    dst_addr;
  logic [DW-1:0] flit_data;
  logic          pkt_done, err_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ni_packetizer #(.DATA_WIDTH(DW), .MAX_LEN(255)) dut (
    .clk(clk), .rst(rst), .cur_addr_rst(cur_addr_rst),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dst(pkt_dst), .pkt_len(pkt_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_id(flit_id),
    .dst_addr(dst_addr), .flit_data(flit_data), .pkt_done(pkt_done), .err_len(err_len)
  );

  typedef struct {
    logic        r;
    logic        pv;
    logic [3:0]  dst;
    logic [7:0]  len;
    logic        dv;
    logic [31:0] din;
    logic        fr;
    logic        e_fv;
    logic [2:0]  e_id;
    logic [3:0]  e_dst;
    logic [31:0] e_data;
    logic        e_pr;
    logic        e_dr;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t        vecs[15];
  logic [34:0] got_q[$];
  logic [34:0] exp_q[5];
  logic [31:0] w[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then wait to the falling edge to sample.
  task automatic drive(input logic r, input logic pv, input logic [3:0] d, input logic [7:0] l,
                       input logic dv, input logic [31:0] din, input logic fr);
    rst = r; pkt_valid = pv; pkt_dst = d; pkt_len = l;
    data_valid = dv; data_in = din; flit_ready = fr;
    @(negedge clk);
  endtask

  task automatic step_end();
    @(posedge clk);
    #1;
  endtask

  task automatic log_xfer();
    if (flit_valid && flit_ready) got_q.push_back({flit_id, flit_data});
  endtask

  initial begin
    int cmd_cnt, hdr_cnt, done_cnt;
    logic prev_done;

    // r pv dst len dv din fr | fv id dst data pr dr done err
    vecs[0]  = '{1'b1, 1'b0, 4'd0,  8'd0, 1'b0, 32'h0,        1'b1, 1'b0, 3'b000, 4'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'd10, 8'd3, 1'b0, 32'h0,        1'b1, 1'b0, 3'b000, 4'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'd0,  8'd0, 1'b1, 32'hA0000001, 1'b1, 1'b1, ID_H,   4'd10, 32'h0000035A, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'd0,  8'd0, 1'b1, 32'hA0000001, 1'b1, 1'b0, 3'b000, 4'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'd0,  8'd0, 1'b1, 32'hB0000002, 1'b1, 1'b1, ID_P,   4'd10, 32'hA0000001, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'd0,  8'd0, 1'b1, 32'hC0000003, 1'b1, 1'b1, ID_P,   4'd10, 32'hB0000002, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'd0,  8'd0, 1'b0, 32'h0,        1'b1, 1'b1, ID_T,   4'd10, 32'hC0000003, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'd0,  8'd0, 1'b0, 32'h0,        1'b1, 1'b0, 3'b000, 4'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'd5,  8'd1, 1'b0, 32'h0,        1'b1, 1'b0, 3'b000, 4'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'd0,  8'd0, 1'b1, 32'hD0000004, 1'b1, 1'b1, ID_H,   4'd5,  32'h00010155, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'd0,  8'd0, 1'b1, 32'hD0000004, 1'b1, 1'b0, 3'b000, 4'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'd0,  8'd0, 1'b0, 32'h0,        1'b1, 1'b1, ID_T,   4'd5,  32'hD0000004, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'd3,  8'd0, 1'b0, 32'h0,        1'b1, 1'b0, 3'b000, 4'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 4'd0,  8'd0, 1'b0, 32'h0,        1'b1, 1'b0, 3'b000, 4'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 4'd0,  8'd0, 1'b0, 32'h0,        1'b1, 1'b0, 3'b000, 4'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0};

    cur_addr_rst = 4'd5;
    rst = 1'b1; pkt_valid = 1'b0; pkt_dst = 4'd0; pkt_len = 8'd0;
    data_valid = 1'b0; data_in = 32'h0; flit_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table: reset state, len=3 packet, len=1 packet to self, len=0 drop.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].r, vecs[i].pv, vecs[i].dst, vecs[i].len, vecs[i].dv, vecs[i].din, vecs[i].fr);
      chk($sformatf("v%0d flit_valid", i), 32'(flit_valid), 32'(vecs[i].e_fv));
      if (vecs[i].e_fv) begin
        chk($sformatf("v%0d flit_id", i),   32'(flit_id),  32'(vecs[i].e_id));
        chk($sformatf("v%0d dst_addr", i),  32'(dst_addr), 32'(vecs[i].e_dst));
        chk($sformatf("v%0d flit_data", i), flit_data,     vecs[i].e_data);
      end
      chk($sformatf("v%0d pkt_ready", i),  32'(pkt_ready),  32'(vecs[i].e_pr));
      chk($sformatf("v%0d data_ready", i), 32'(data_ready), 32'(vecs[i].e_dr));
      chk($sformatf("v%0d pkt_done", i),   32'(pkt_done),   32'(vecs[i].e_done));
      chk($sformatf("v%0d err_len", i),    32'(err_len),    32'(vecs[i].e_err));
      step_end();
    end

    // Stall for 5 cycles mid-body on a len=4 packet (pkt_id 2).
    for (int k = 0; k < 4; k++) w[k] = 32'hC0DE0000 + 32'(k);
    got_q.delete();
    drive(1'b0, 1'b1, 4'd6, 8'd4, 1'b0, 32'h0, 1'b1);
    chk("t3 cmd pkt_ready", 32'(pkt_ready), 32'd1);
    step_end();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, w[0], 1'b1); log_xfer(); step_end();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, w[0], 1'b1);
    chk("t3 first data_ready", 32'(data_ready), 32'd1);
    log_xfer(); step_end();
    for (int s = 0; s < 5; s++) begin
      drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, w[1], 1'b0);
      chk("t3 stall flit_valid", 32'(flit_valid), 32'd1);
      chk("t3 stall flit_id", 32'(flit_id), 32'(ID_P));
      chk("t3 stall dst_addr", 32'(dst_addr), 32'd6);
      chk("t3 stall flit_data", flit_data, w[0]);
      chk("t3 stall data_ready", 32'(data_ready), 32'd0);
      log_xfer(); step_end();
    end
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b0, 4'd0, 8'd0, (k < 4), (k < 4) ? w[k % 4] : 32'h0, 1'b1);
      if (k == 4) chk("t3 pkt_done", 32'(pkt_done), 32'd1);
      log_xfer(); step_end();
    end
    exp_q[0] = {ID_H, 32'h00020456};
    exp_q[1] = {ID_P, w[0]};
    exp_q[2] = {ID_P, w[1]};
    exp_q[3] = {ID_P, w[2]};
    exp_q[4] = {ID_T, w[3]};
    chk("t3 flit count", 32'(got_q.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < got_q.size()) chk($sformatf("t3 flit %0d", k), got_q[k][31:0], exp_q[k][31:0]);
      if (k < got_q.size()) chk($sformatf("t3 id %0d", k), 32'(got_q[k][34:32]), 32'(exp_q[k][34:32]));
    end

    // Reset after the HEADER of a len=4 packet (pkt_id 3); cur_addr re-sampled as 7.
    drive(1'b0, 1'b1, 4'd9, 8'd4, 1'b0, 32'h0, 1'b1); step_end();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, w[0], 1'b1);
    chk("t5 header data", flit_data, 32'h00030459);
    step_end();
    cur_addr_rst = 4'd7;
    drive(1'b1, 1'b0, 4'd0, 8'd0, 1'b1, w[0], 1'b1); step_end();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, w[0], 1'b1);
    chk("t5 flit_valid after rst", 32'(flit_valid), 32'd0);
    chk("t5 data_ready after rst", 32'(data_ready), 32'd0);
    chk("t5 pkt_ready after rst", 32'(pkt_ready), 32'd1);
    step_end();
    drive(1'b0, 1'b1, 4'd2, 8'd1, 1'b0, 32'h0, 1'b1); step_end();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 32'h12345678, 1'b1);
    chk("t5 new header id", 32'(flit_id), 32'(ID_H));
    chk("t5 new header data", flit_data, 32'h00000172);
    step_end();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 32'h12345678, 1'b1); step_end();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 32'h0, 1'b1);
    chk("t5 tail id", 32'(flit_id), 32'(ID_T));
    chk("t5 tail data", flit_data, 32'h12345678);
    chk("t5 pkt_done", 32'(pkt_done), 32'd1);
    step_end();

    // 257 back-to-back len=1 packets from a fresh reset: pkt_id wraps on the last.
    drive(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 32'h0, 1'b1); step_end();
    cmd_cnt = 0; hdr_cnt = 0; done_cnt = 0; prev_done = 1'b0;
    for (int c = 0; c < 900 && done_cnt < 257; c++) begin
      drive(1'b0, (cmd_cnt < 257), 4'd1, 8'd1, 1'b1, 32'h600D0000 + 32'(c), 1'b1);
      if (prev_done) chk("t6 header right after tail", 32'(flit_valid && flit_id == ID_H), 32'd1);
      if (flit_valid && flit_id == ID_H) begin
        chk($sformatf("t6 pkt_id %0d", hdr_cnt), 32'(flit_data[23:16]), 32'(hdr_cnt[7:0]));
        hdr_cnt++;
      end
      if (pkt_valid && pkt_ready) cmd_cnt++;
      prev_done = pkt_done;
      if (pkt_done) done_cnt++;
      step_end();
    end
    chk("t6 packets done", 32'(done_cnt), 32'd257);
    chk("t6 headers seen", 32'(hdr_cnt), 32'd257);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
